regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- 32-entry x 32-bit register file. It is the consuming end of the write-back path: it takes the registered write-back data WD3 together with A3/WE3.
- Provides two read ports (A1/A2 -> RD1/RD2), with same-cycle write-to-read bypass.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight producers, e.g. multi-cycle loads.
- Sits between decode (read and issue) and write-back (write).

Parameters:
- DW, 32, data width.
- AW, 5, register address width; depth = 2**AW.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A1  input  AW  read port 1 address.
- A2  input  AW  read port 2 address.
- RD1  output  DW  read port 1 data.
- RD2  output  DW  read port 2 data.
- RD1_ok  output  1  RD1 holds the architecturally current value (no pending producer).
- RD2_ok  output  1  same for RD2.
- issue_we  input  1  decode issues an instruction that will write issue_A.
- issue_A  input  AW  destination of the issued instruction.
- WE3  input  1  write-back enable.
- A3  input  AW  write-back address.
- WD3  input  DW  write-back data (from the write-back pipeline register).
- pend_cnt  output  AW+1  number of registers currently marked pending.
- stall  output  1  hazard indication: (~RD1_ok | ~RD2_ok).

Behaviour:
- Interface: reset is asynchronous and active-low; the clock is CLK.
- Reset (reset=0, asynchronous):
  - All 32 registers cleared to 0.
  - All busy bits cleared; pend_cnt=0.
  - Outputs while in reset: RD1=RD2=0, RD1_ok=RD2_ok=1, stall=0.
- Register 0:
  - Reads always return 0.
  - Writes are ignored.
  - Its busy bit is never set, so RDx_ok=1 whenever Ax=0.
- Write: at the rising CLK edge, if WE3=1 and A3!=0, then regs[A3] <= WD3.
- Read (combinational, zero latency):
  - RDx = 0 if Ax=0.
  - Else RDx = WD3 if (WE3 && A3==Ax) (bypass).
  - Else RDx = regs[Ax].
- Readiness: RDx_ok = (Ax==0) | ~busy[Ax] | (WE3 && A3==Ax).
  - A value arriving this cycle through the bypass counts as ready.
- Scoreboard update at the rising CLK edge, for each register r != 0:
  - set = issue_we && issue_A==r.
  - clr = WE3 && A3==r.
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r]).
  - Simultaneous set and clr on the same r: set wins. The newer producer owns the register; the write data is still stored.
  - issue_A=0 sets nothing.
  - WE3 to a non-busy register writes normally with no scoreboard effect. No error is flagged.
  - A second issue to an already-busy register leaves it busy (no count). The newest write-back clears it.
- pend_cnt: registered population count of the busy bits, updated with them at the same edge. Range 0..31, never wraps.
- stall: combinational from RDx_ok. The block does not gate issue_we; decode must not issue while stall=1.
- Reset mid-operation: asserting reset in the middle of operation drops all pending state immediately. Write-backs of old producers arriving after reset release write data only.
- No X propagation: every output is defined for every input combination.

Test Plan:
- Reset, then read A1=5, A2=0 -> RD1=0, RD2=0, RD1_ok=RD2_ok=1, pend_cnt=0, stall=0.
- WE3=1, A3=7, WD3=0xDEADBEEF with A1=7 in the same cycle -> RD1=0xDEADBEEF (bypass). Next cycle WE3=0 -> RD1 still 0xDEADBEEF.
- WE3=1, A3=0, WD3=0x12345678, then A1=0 -> RD1=0, RD1_ok=1.
- Scoreboard sequence:
  - issue_we=1, issue_A=9 -> next cycle A1=9 gives RD1_ok=0, stall=1, pend_cnt=1.
  - Then WE3=1, A3=9, WD3=0xA5A5A5A5 -> same cycle RD1_ok=1, RD1=0xA5A5A5A5, stall=0.
  - Next cycle pend_cnt=0.
- Simultaneous events on r3 (busy): issue_we=1, issue_A=3 and WE3=1, A3=3, WD3=0x11 in the same cycle -> after the edge busy[3]=1, pend_cnt=1, regs[3]=0x11.
- Issue to registers 1..31 on consecutive cycles -> pend_cnt reaches 31. Assert reset mid-sequence -> pend_cnt=0, all RDx_ok=1, RDx=0 immediately without a clock edge.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// 2^AW x DW register file with write-back bypass on both read ports and a
// per-register pending-write scoreboard for decode-side RAW hazard detection.
module regfile_wb_scoreboard #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          RD1_ok,
  output logic          RD2_ok,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_A,
  input  logic          WE3,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD3,
  output logic [AW:0]   pend_cnt,
  output logic          stall
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      pend_q;
  logic [AW:0]      pend_d;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  // Architectural storage; register 0 is never written and stays zero.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WE3 && (A3 != '0)) begin
      regs_q[A3] <= WD3;
    end
  end

  // Scoreboard next state: a new issue wins over a same-cycle write-back,
  // since the newer producer now owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (issue_we && (issue_A == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (WE3 && (A3 == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    busy_d[0] = 1'b0;
    pend_d    = popcount(busy_d);
  end

  // Busy bits and their population count advance together.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // Read port 1: reset forces a quiet, ready zero regardless of write-back.
  always_comb begin
    RD1    = '0;
    RD1_ok = 1'b1;
    if (!reset) begin
      RD1    = '0;
      RD1_ok = 1'b1;
    end else if (A1 == '0) begin
      RD1    = '0;
      RD1_ok = 1'b1;
    end else if (WE3 && (A3 == A1)) begin
      RD1    = WD3;
      RD1_ok = 1'b1;
    end else begin
      RD1    = regs_q[A1];
      RD1_ok = ~busy_q[A1];
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    RD2    = '0;
    RD2_ok = 1'b1;
    if (!reset) begin
      RD2    = '0;
      RD2_ok = 1'b1;
    end else if (A2 == '0) begin
      RD2    = '0;
      RD2_ok = 1'b1;
    end else if (WE3 && (A3 == A2)) begin
      RD2    = WD3;
      RD2_ok = 1'b1;
    end else begin
      RD2    = regs_q[A2];
      RD2_ok = ~busy_q[A2];
    end
  end

  assign stall    = ~RD1_ok | ~RD2_ok;
  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Scoreboard bench: expected outputs are queued when inputs are driven and
// popped against the DUT one time unit later, mid-cycle.
module tb_regfile_wb_scoreboard;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, issue_A, A3;
  logic        issue_we, WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;
  logic        RD1_ok, RD2_ok, stall;
  logic [5:0]  pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic        ok1;
    logic [31:0] rd2;
    logic        ok2;
    logic        stl;
    logic [5:0]  pend;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  always #5 CLK = ~CLK;

  regfile_wb_scoreboard #(.DW(32), .AW(5)) dut (
    .CLK(CLK), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RD1_ok(RD1_ok), .RD2_ok(RD2_ok), .issue_we(issue_we), .issue_A(issue_A),
    .WE3(WE3), .A3(A3), .WD3(WD3), .pend_cnt(pend_cnt), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] m_pend();
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c = c + 6'd1;
    return c;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'd0;
    if (WE3 && A3 == a) return WD3;
    return m_regs[a];
  endfunction

  function automatic logic m_ok(input logic [4:0] a);
    if (!reset || a == 5'd0) return 1'b1;
    if (WE3 && A3 == a) return 1'b1;
    return !m_busy[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One cycle: drive at negedge, queue expectation, compare, then advance the model.
  task automatic cyc(input string tag, input logic rst, input logic iwe, input logic [4:0] ia,
                     input logic we, input logic [4:0] a3, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2);
    exp_t e, g;
    @(negedge CLK);
    reset = rst; issue_we = iwe; issue_A = ia; WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2;
    if (!rst) m_clear();
    e.tag  = tag;
    e.rd1  = m_rd(a1);
    e.ok1  = m_ok(a1);
    e.rd2  = m_rd(a2);
    e.ok2  = m_ok(a2);
    e.stl  = !(e.ok1 && e.ok2);
    e.pend = m_pend();
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    check({g.tag, ".RD1"},    RD1,             g.rd1);
    check({g.tag, ".RD1_ok"}, {31'd0, RD1_ok}, {31'd0, g.ok1});
    check({g.tag, ".RD2"},    RD2,             g.rd2);
    check({g.tag, ".RD2_ok"}, {31'd0, RD2_ok}, {31'd0, g.ok2});
    check({g.tag, ".stall"},  {31'd0, stall},  {31'd0, g.stl});
    check({g.tag, ".pend"},   {26'd0, pend_cnt}, {26'd0, g.pend});
    if (rst) begin
      if (we && a3 != 5'd0) m_regs[a3] = wd;
      for (int r = 1; r < 32; r++) begin
        if (iwe && ia == 5'(r)) m_busy[r] = 1'b1;
        else if (we && a3 == 5'(r)) m_busy[r] = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0; issue_we = 1'b0; issue_A = 5'd0; WE3 = 1'b0; A3 = 5'd0;
    WD3 = 32'd0; A1 = 5'd0; A2 = 5'd0;
    m_clear();

    cyc("rst_hold", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    cyc("rst_rel",  1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("tp_reset_pend", {26'd0, pend_cnt}, 32'd0);

    cyc("bypass", 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
    check("tp_bypass", RD1, 32'hDEADBEEF);
    cyc("stored", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    check("tp_stored", RD2, 32'hDEADBEEF);

    cyc("r0_wr", 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd7);
    cyc("r0_rd", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("tp_r0", RD1, 32'd0);

    cyc("iss9",   1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    cyc("busy9",  1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("tp_busy9_stall", {31'd0, stall}, 32'd1);
    check("tp_busy9_pend",  {26'd0, pend_cnt}, 32'd1);
    cyc("wb9",    1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0);
    check("tp_wb9", RD1, 32'hA5A5A5A5);
    cyc("clr9",   1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("tp_clr9_pend", {26'd0, pend_cnt}, 32'd0);

    cyc("iss3",   1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    cyc("sim3",   1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 32'h11, 5'd3, 5'd0);
    cyc("after3", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("tp_sim3_data", RD1, 32'h11);
    check("tp_sim3_ok",   {31'd0, RD1_ok}, 32'd0);
    check("tp_sim3_pend", {26'd0, pend_cnt}, 32'd1);
    cyc("wb3",    1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
    cyc("iss4a",  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
    cyc("iss4b",  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
    cyc("iss0",   1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    check("tp_double_issue_pend", {26'd0, pend_cnt}, 32'd1);
    cyc("wb4",    1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    cyc("wb_idle",1'b1, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0FFEE, 5'd12, 5'd4);
    check("tp_idle_pend", {26'd0, pend_cnt}, 32'd0);

    for (int r = 1; r < 32; r++) begin
      cyc("fill", 1'b1, 1'b1, 5'(r), 1'b0, 5'd0, 32'd0, 5'(r), 5'(r - 1));
    end
    cyc("full", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9);
    check("tp_full_pend", {26'd0, pend_cnt}, 32'd31);

    cyc("midrst", 1'b0, 1'b1, 5'd6, 1'b1, 5'd9, 32'h55, 5'd9, 5'd3);
    check("tp_midrst_pend", {26'd0, pend_cnt}, 32'd0);
    check("tp_midrst_rd1",  RD1, 32'd0);
    cyc("late_wb", 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h77, 5'd3, 5'd9);
    cyc("late_rd", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd3);
    check("tp_late_wb", RD1, 32'h77);

    for (int i = 0; i < 300; i++) begin
      cyc("rand", 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
